vpu_iter_ctrl: RTL and testbench
================================

# vpu_iter_ctrl

Iteration scheduler for the LDPC GF(257) decoder's variable-processing unit (VPU). It drives the enable of the VPU address generator bank for one pass per decoding iteration. Between passes it holds the enable low so every address counter reloads its row start offset. It also produces the delayed write strobe for the VPU write-back pipeline, counts iterations, and terminates decoding on the iteration limit or an early syndrome pass. It sits between the decoder top-level control and the VPU address generator / VPU datapath.

## Interface
- PASS_LEN, 256, cycles per VPU pass (addr_en high duration); legal range 2..65535
- PIPE_LAT, 4, VPU read-to-write pipeline latency in cycles; legal range 1..16
- ITER_WIDTH, 6, width of iteration limit/counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request to decode one frame; sampled only in IDLE
- max_iter  in  ITER_WIDTH  iteration limit; sampled on start accept; 0 treated as 1
- syn_ok  in  1  syndrome-check pass from check-node side; sampled only in CHECK
- addr_en  out  1  enable to VPU address generator; low = reload row starts
- wr_en  out  1  VPU write-back strobe = addr_en delayed PIPE_LAT cycles
- busy  out  1  high from first RUN cycle through DONE inclusive
- iter_cnt  out  ITER_WIDTH  completed passes in current/last frame
- done  out  1  one-cycle pulse, frame finished
- early_stop  out  1  last frame ended on syn_ok; held until next start accept

## Operation
- States: IDLE, RUN, DRAIN, CHECK, DONE; one-hot or binary, registered outputs.
- IDLE: on start=1, latch max_iter (0→1), clear iter_cnt and early_stop, load pass counter 0, go RUN.
- RUN: addr_en=1. The pass counter increments from 0 to PASS_LEN-1. On the last count, iter_cnt increments and the state goes to DRAIN.
- DRAIN: addr_en=0, lasting PIPE_LAT cycles, so the wr_en tail completes. Then go to CHECK.
- CHECK: one cycle with addr_en=0, which guarantees at least PIPE_LAT+1 reload cycles between passes.
  - If syn_ok=1, set early_stop=1 and go to DONE.
  - Else, if iter_cnt == latched limit, go to DONE.
  - Else, go to RUN with the pass counter at 0.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- wr_en: a PIPE_LAT-deep shift register fed by addr_en, cleared by reset.
- iter_cnt: no wrap is possible, because the limit is at most 2^ITER_WIDTH-1.
- start while busy: ignored; no queueing.
- syn_ok outside CHECK: ignored.
- Reset mid-operation: all state clears immediately. The shift register clears, so no stray wr_en occurs.

## Timing
- Reset values:
  - state = IDLE
  - addr_en = 0
  - wr_en = 0
  - busy = 0
  - iter_cnt = 0
  - done = 0
  - early_stop = 0
- start accepted at edge T gives busy=1 and addr_en=1 from cycle T+1.
- Pass k (k≥1) occupies the following cycles:
  - RUN: T+1+(k-1)·P to T+(k-1)·P+PASS_LEN, where P = PASS_LEN+PIPE_LAT+1
  - DRAIN: the next PIPE_LAT cycles
  - CHECK: cycle T+k·P
- wr_en is high for exactly PASS_LEN cycles per pass, starting PIPE_LAT cycles after addr_en rises.
- DONE (done=1) occurs at cycle T+n·P+1 for n completed passes. busy falls at T+n·P+2.
- A start presented on the DONE cycle is ignored. It is accepted only from IDLE.

## Configuration
- VPU_ITER_CTRL_EARLY_STOP_EN defined: syn_ok is evaluated in CHECK as above.
- Undefined: the syn_ok input is present but ignored, early_stop is tied 0, and every frame runs exactly the latched limit.

## Test plan
- Reset/idle: rst_n low for 3 cycles, then high, no start → all outputs 0 for 1000 cycles.
- Full run (PASS_LEN=256, PIPE_LAT=4, max_iter=3, syn_ok=0):
  - start accepted at T → addr_en high T+1..T+256, T+262..T+517, T+523..T+778
  - wr_en high on the same windows shifted +4
  - done at T+784, iter_cnt=3, early_stop=0
- Early stop: max_iter=10, syn_ok=1 only at T+522 → done at T+523, iter_cnt=2, early_stop=1.
  - With the macro undefined → 10 passes, done at T+2611.
- max_iter=0 → exactly one pass, done at T+262, iter_cnt=1.
- Start while busy, pulsed at T+100 and T+300 → no effect on the timeline; done still at T+784 for max_iter=3.
- Async reset at T+400 (mid second pass) → all outputs 0 before the next edge.
  - A new start then begins a fresh frame with iter_cnt=0 and no stray wr_en.

Source files
------------

// File: rtl/vpu_iter_ctrl.sv
// Iteration scheduler for the LDPC VPU: one addr_en pass per iteration, drain/check gaps, delayed wr_en.
// Optional early stop on syndrome pass is compiled in with VPU_ITER_CTRL_EARLY_STOP_EN.
module vpu_iter_ctrl #(
  parameter int PASS_LEN   = 256,
  parameter int PIPE_LAT   = 4,
  parameter int ITER_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] max_iter,
  input  logic                  syn_ok,
  output logic                  addr_en,
  output logic                  wr_en,
  output logic                  busy,
  output logic [ITER_WIDTH-1:0] iter_cnt,
  output logic                  done,
  output logic                  early_stop,
  output logic [2:0]            dbg_state
);

`ifdef VPU_ITER_CTRL_EARLY_STOP_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  localparam int CW = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0] PASS_LAST  = CW'(PASS_LEN - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         pass_cnt, pass_nxt;
  logic [DW-1:0]         drain_cnt, drain_nxt;
  logic [ITER_WIDTH-1:0] limit, limit_nxt, iter_nxt;
  logic                  early_nxt;
  logic [PIPE_LAT-1:0]   wr_sr;

  always_comb begin
    state_nxt = state;
    pass_nxt  = pass_cnt;
    drain_nxt = drain_cnt;
    limit_nxt = limit;
    iter_nxt  = iter_cnt;
    early_nxt = early_stop;
    case (state)
      S_IDLE: begin
        if (start) begin
          limit_nxt = (max_iter == '0) ? ITER_WIDTH'(1) : max_iter;
          iter_nxt  = '0;
          early_nxt = 1'b0;
          pass_nxt  = '0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (pass_cnt == PASS_LAST) begin
          iter_nxt  = iter_cnt + ITER_WIDTH'(1);
          drain_nxt = '0;
          state_nxt = S_DRAIN;
        end else begin
          pass_nxt = pass_cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = S_CHECK;
        else                         drain_nxt = drain_cnt + DW'(1);
      end
      S_CHECK: begin
        if (EARLY_EN && syn_ok) begin
          early_nxt = 1'b1;
          state_nxt = S_DONE;
        end else if (iter_cnt == limit) begin
          state_nxt = S_DONE;
        end else begin
          pass_nxt  = '0;
          state_nxt = S_RUN;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered off the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pass_cnt   <= '0;
      drain_cnt  <= '0;
      limit      <= '0;
      iter_cnt   <= '0;
      early_stop <= 1'b0;
      addr_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_sr      <= '0;
    end else begin
      state      <= state_nxt;
      pass_cnt   <= pass_nxt;
      drain_cnt  <= drain_nxt;
      limit      <= limit_nxt;
      iter_cnt   <= iter_nxt;
      early_stop <= early_nxt;
      addr_en    <= (state_nxt == S_RUN);
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_DONE);
      wr_sr[0]   <= addr_en;
      for (int i = 1; i < PIPE_LAT; i++) wr_sr[i] <= wr_sr[i-1];
    end
  end

  assign wr_en     = wr_sr[PIPE_LAT-1];
  assign dbg_state = state;

endmodule

// File: tb/tb_vpu_iter_ctrl.sv
// Bench for vpu_iter_ctrl: timeline-arithmetic reference model, per-cycle compare, directed literal checks.
module tb_vpu_iter_ctrl;
  localparam int PASS_LEN   = 256;
  localparam int PIPE_LAT   = 4;
  localparam int ITER_WIDTH = 6;
  localparam int P          = PASS_LEN + PIPE_LAT + 1;
`ifdef VPU_ITER_CTRL_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic                  clk, rst_n, start, syn_ok;
  logic [ITER_WIDTH-1:0] max_iter;
  logic                  addr_en, wr_en, busy, done, early_stop;
  logic [ITER_WIDTH-1:0] iter_cnt;
  logic [2:0]            dbg_state;

  vpu_iter_ctrl #(.PASS_LEN(PASS_LEN), .PIPE_LAT(PIPE_LAT), .ITER_WIDTH(ITER_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_iter(max_iter), .syn_ok(syn_ok),
    .addr_en(addr_en), .wr_en(wr_en), .busy(busy), .iter_cnt(iter_cnt), .done(done),
    .early_stop(early_stop), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame timeline from acceptance edge t0 with pass period P.
  int                    cyc = 0;
  int                    t0 = 0, lim = 1, done_at = 0, fin_iter = 0;
  int                    xp, x, r, lab;
  bit                    active = 0, early_m = 0;
  logic                  exp_addr = 0, exp_wr = 0, exp_busy = 0, exp_done = 0, exp_early = 0;
  logic [ITER_WIDTH-1:0] exp_iter = '0;
  logic [0:0]            exp_q[$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      active = 0; done_at = 0; early_m = 0; fin_iter = 0;
      exp_addr = 0; exp_wr = 0; exp_busy = 0; exp_done = 0; exp_early = 0; exp_iter = '0;
      exp_q.delete();
      for (int i = 0; i < PIPE_LAT; i++) exp_q.push_back(1'b0);
    end else begin
      cyc++;
      if (active && done_at == 0) begin
        xp = cyc - t0;
        if (xp > 0 && xp % P == 0) begin
          if (EARLY && syn_ok) begin
            early_m = 1; done_at = cyc + 1; fin_iter = xp / P;
          end else if (xp / P == lim) begin
            done_at = cyc + 1; fin_iter = xp / P;
          end
        end
      end
      if (start && (!active || (done_at != 0 && cyc > done_at))) begin
        active = 1; t0 = cyc; lim = (max_iter == 0) ? 1 : int'(max_iter);
        done_at = 0; early_m = 0;
      end
      exp_q.push_back(exp_addr);
      void'(exp_q.pop_front());
      exp_wr = exp_q[0];
      lab = cyc + 1;
      exp_addr = 0; exp_busy = 0; exp_done = 0; exp_early = early_m;
      if (!active) begin
        exp_iter = '0;
      end else if (done_at != 0 && lab >= done_at) begin
        exp_iter = ITER_WIDTH'(fin_iter);
        exp_done = (lab == done_at);
        exp_busy = exp_done;
      end else begin
        x = lab - t0;
        r = (x - 1) % P;
        exp_addr = (r < PASS_LEN);
        exp_busy = 1;
        exp_iter = ITER_WIDTH'((x - 1) / P + ((r >= PASS_LEN) ? 1 : 0));
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  initial forever begin
    @(negedge clk);
    check("cycle_outputs",
          32'({addr_en, wr_en, busy, done, early_stop, iter_cnt}),
          32'({exp_addr, exp_wr, exp_busy, exp_done, exp_early, exp_iter}));
  end

  // syn_ok driver: either a single targeted cycle or random noise
  int syn_label = 0;
  bit syn_rand  = 0;
  initial begin
    syn_ok = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      syn_ok = syn_rand ? ($urandom_range(0, 3) == 0) : (syn_label != 0 && cyc + 1 == syn_label);
    end
  end

  // driver tasks
  int t_acc = 0;

  task automatic do_start(input logic [ITER_WIDTH-1:0] mi);
    @(posedge clk);
    #1;
    start = 1'b1;
    max_iter = mi;
    @(posedge clk);
    #1;
    t_acc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_label(input int off);
    bit hit = 0;
    for (int n = 0; n < 4000 && !hit; n++) begin
      @(negedge clk);
      if (cyc + 1 - t_acc == off) hit = 1;
    end
    if (!hit) check("label_timeout", 32'(off), 32'(-1));
  endtask

  task automatic probe(input int off, input logic ea, input logic ew);
    wait_label(off);
    check($sformatf("win_%0d", off), 32'({addr_en, wr_en}), 32'({ea, ew}));
  endtask

  task automatic wait_done(input int budget, output int off);
    off = -1;
    for (int n = 0; n < budget && off < 0; n++) begin
      @(negedge clk);
      if (done === 1'b1) off = cyc + 1 - t_acc;
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
  endtask

  int off;

  initial begin
    rst_n = 1'b1; start = 1'b0; max_iter = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle with no start
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("idle_outputs", 32'({addr_en, wr_en, busy, done, early_stop, iter_cnt}), 32'd0);

    // full run, max_iter=3
    do_start(6'd3);
    probe(1, 1, 0);   probe(4, 1, 0);   probe(5, 1, 1);   probe(256, 1, 1);
    probe(257, 0, 1); probe(260, 0, 1); probe(261, 0, 0); probe(262, 1, 0);
    probe(266, 1, 1); probe(778, 1, 1); probe(779, 0, 1); probe(782, 0, 1);
    probe(783, 0, 0);
    wait_done(200, off);
    check("full_done_time", 32'(off), 32'd784);
    check("full_iter", 32'(iter_cnt), 32'd3);
    check("full_early", 32'(early_stop), 32'd0);
    settle();

    // early stop on syn_ok at the second CHECK
    do_start(6'd10);
    syn_label = t_acc + 522;
    wait_done(3000, off);
    syn_label = 0;
    check("early_done_time", 32'(off), EARLY ? 32'd523 : 32'd2611);
    check("early_iter", 32'(iter_cnt), EARLY ? 32'd2 : 32'd10);
    check("early_flag", 32'(early_stop), EARLY ? 32'd1 : 32'd0);
    settle();

    // max_iter=0 behaves as one pass
    do_start(6'd0);
    wait_done(400, off);
    check("zero_done_time", 32'(off), 32'd262);
    check("zero_iter", 32'(iter_cnt), 32'd1);
    check("zero_early_clr", 32'(early_stop), 32'd0);
    settle();

    // start pulses while busy are ignored
    do_start(6'd3);
    fork
      begin
        wait_label(100);
        start = 1'b1; max_iter = 6'd7;
        @(posedge clk); #1 start = 1'b0;
        wait_label(300);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      wait_done(1000, off);
    join
    check("busy_start_done_time", 32'(off), 32'd784);
    check("busy_start_iter", 32'(iter_cnt), 32'd3);
    settle();

    // async reset mid second pass, then a fresh frame
    do_start(6'd3);
    wait_label(400);
    #2 rst_n = 1'b0;
    #1 check("async_rst_outputs", 32'({addr_en, wr_en, busy, done, early_stop, iter_cnt}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_start(6'd1);
    wait_label(1);
    check("fresh_iter", 32'(iter_cnt), 32'd0);
    check("fresh_wr", 32'(wr_en), 32'd0);
    wait_done(400, off);
    check("fresh_done_time", 32'(off), 32'd262);
    settle();

    // random traffic: starts at any time, random limits, noisy syn_ok
    syn_rand = 1;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 5) == 0);
      max_iter = ITER_WIDTH'($urandom_range(0, 7));
    end
    start = 1'b0;
    syn_rand = 0;
    for (int n = 0; n < 3000 && busy; n++) @(posedge clk);
    @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
